uart_rx_path: RTL and testbench

UART_RX_PATH -- requirements
Module: uart_rx_path

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 74 +++++++
 rtl/uart_rx_path.sv | 158 +++++++++++++++
 tb/tb_uart_rx_path.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART receive path.
// The optional stop-bit check is enabled by defining UART_RX_FRAME_ERR_EN.
package uart_pkg;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int DEF_DVSR    = 27;
    localparam int DEF_FIFO_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO, depth 2**AW, width DW.
// Full/empty are tracked as flags updated by the last operation.
module uart_rx_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [DW-1:0] w_data,
    input  logic          rd,
    output logic [DW-1:0] r_data,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] mem_reg [0:(2**AW)-1];
    logic [AW-1:0] w_ptr_reg;
    logic [AW-1:0] r_ptr_reg;
    logic          full_reg;
    logic          empty_reg;
    logic          rd_en;
    logic          wr_en;

    // A pop frees the slot this cycle, so a full FIFO may still accept a push.
    assign rd_en = rd && !empty_reg;
    assign wr_en = wr && (!full_reg || rd_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[w_ptr_reg] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_reg <= '0;
            r_ptr_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            case ({wr_en, rd_en})
                2'b01: begin
                    r_ptr_reg <= r_ptr_reg + AW'(1);
                    full_reg  <= 1'b0;
                    if ((r_ptr_reg + AW'(1)) == w_ptr_reg) begin
                        empty_reg <= 1'b1;
                    end
                end
                2'b10: begin
                    w_ptr_reg <= w_ptr_reg + AW'(1);
                    empty_reg <= 1'b0;
                    if ((w_ptr_reg + AW'(1)) == r_ptr_reg) begin
                        full_reg <= 1'b1;
                    end
                end
                2'b11: begin
                    w_ptr_reg <= w_ptr_reg + AW'(1);
                    r_ptr_reg <= r_ptr_reg + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign r_data = mem_reg[r_ptr_reg];
    assign empty  = empty_reg;
    assign full   = full_reg;

endmodule

// File: rtl/uart_rx_path.sv
// UART receiver: synchronizer, oversample tick generator, frame FSM and FIFO.
// Define UART_RX_FRAME_ERR_EN to check the stop bit and drop bad frames.
module uart_rx_path
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int DVSR    = DEF_DVSR,
    parameter int FIFO_W  = DEF_FIFO_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err
);

    localparam int TW = cnt_width(DVSR - 1);
    localparam int SW = cnt_width(((SB_TICK > 16) ? SB_TICK : 16) - 1);
    localparam int NW = cnt_width(DBIT - 1);

    logic [TW-1:0]   tick_cnt_reg;
    logic            s_tick;
    logic            rx_meta_reg;
    logic            rx_sync_reg;
    rx_state_t       state_reg;
    logic [SW-1:0]   s_reg;
    logic [NW-1:0]   n_reg;
    logic [DBIT-1:0] b_reg;
    logic            push_reg;
`ifdef UART_RX_FRAME_ERR_EN
    logic            frame_err_reg;
`endif

    assign s_tick = (tick_cnt_reg == TW'(DVSR - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_reg <= '0;
        end else if (s_tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end
    end

    // Idle-high reset value keeps a reset release from looking like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            s_reg         <= '0;
            n_reg         <= '0;
            b_reg         <= '0;
            push_reg      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_reg <= 1'b0;
`endif
        end else begin
            push_reg      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (!rx_sync_reg) begin
                        state_reg <= START;
                        s_reg     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_reg == SW'(7)) begin
                            // Mid start bit: a high line here was only a glitch.
                            if (!rx_sync_reg) begin
                                state_reg <= DATA;
                                s_reg     <= '0;
                                n_reg     <= '0;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            s_reg <= s_reg + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_reg == SW'(15)) begin
                            s_reg <= '0;
                            b_reg <= {rx_sync_reg, b_reg[DBIT-1:1]};
                            if (n_reg == NW'(DBIT - 1)) begin
                                state_reg <= STOP;
                            end else begin
                                n_reg <= n_reg + NW'(1);
                            end
                        end else begin
                            s_reg <= s_reg + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_reg == SW'(SB_TICK - 1)) begin
                            state_reg <= IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                            if (rx_sync_reg) begin
                                push_reg <= 1'b1;
                            end else begin
                                frame_err_reg <= 1'b1;
                            end
`else
                            push_reg <= 1'b1;
`endif
                        end else begin
                            s_reg <= s_reg + SW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err = frame_err_reg;
`else
    assign frame_err = 1'b0;
`endif

    // b_reg holds still while in IDLE, so it is the pushed byte during push_reg.
    uart_rx_fifo #(
        .DW(DBIT),
        .AW(FIFO_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (push_reg),
        .w_data (b_reg),
        .rd     (rd_uart),
        .r_data (r_data),
        .empty  (rx_empty),
        .full   (rx_full)
    );

endmodule

// File: tb/tb_uart_rx_path.sv
// Randomized scoreboard bench for uart_rx_path (DVSR=2, 32 clk per bit, 4-deep FIFO).
// Follows the UART_RX_FRAME_ERR_EN setting of the build for the stop-bit model.
module tb_uart_rx_path;

    localparam int BIT_CLK = 32;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rd_uart = 1'b0;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int fe_seen = 0;
    int fe_exp = 0;
    int fe_long = 0;
    logic fe_prev = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_path #(
        .DBIT(8),
        .SB_TICK(16),
        .DVSR(2),
        .FIFO_W(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_uart   (rd_uart),
        .r_data    (r_data),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared with the head of the expected queue.
    always @(negedge clk) begin
        if (frame_err) begin
            fe_seen++;
            if (fe_prev) fe_long++;
        end
        fe_prev = frame_err;
        if (!reset && rd_uart && !rx_empty) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected actual=%02h required=none", r_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (r_data !== e) begin
                    failures++;
                    $display("FAIL pop_data actual=%02h required=%02h", r_data, e);
                end else begin
                    $display("pop r_data=%02h", r_data);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        chk("reset_rx_empty", 32'(rx_empty), 32'd1);
        chk("reset_rx_full", 32'(rx_full), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_r_data", 32'(r_data), 32'd0);
    endtask

    task automatic check_fifo_state();
        chk("rx_empty", 32'(rx_empty), 32'(exp_q.size() == 0));
        chk("rx_full", 32'(rx_full), 32'(exp_q.size() == DEPTH));
        if (exp_q.size() > 0) chk("r_data_head", 32'(r_data), 32'(exp_q[0]));
        chk("frame_err_count", 32'(fe_seen), 32'(fe_exp));
    endtask

    // Drives one frame; a bad stop bit is held low for only part of the bit so the
    // line is high again before a spurious start could be accepted.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int abort_at);
        logic [9:0] bits;
        int cyc = 0;
        int len;
        bits = {stop_ok, d, 1'b0};
        $display("send data=%02h stop_ok=%0d abort_at=%0d", d, stop_ok, abort_at);
        for (int b = 0; b < 10; b++) begin
            len = (b == 9 && !stop_ok) ? 24 : BIT_CLK;
            for (int c = 0; c < len; c++) begin
                rx = bits[b];
                step(1);
                cyc++;
                if (abort_at > 0 && cyc == abort_at) begin
                    reset = 1'b1;
                    rx = 1'b1;
                    exp_q.delete();
                    step(1);
                    check_reset_outputs();
                    step(2);
                    reset = 1'b0;
                    step(40);
                    return;
                end
            end
        end
        rx = 1'b1;
        step(40);
    endtask

    // Reference rule: a frame is kept if its stop bit is acceptable and the FIFO has room.
    task automatic send_and_model(input logic [7:0] d, input bit stop_ok);
        bit stored;
        send_frame(d, stop_ok, 0);
`ifdef UART_RX_FRAME_ERR_EN
        stored = stop_ok;
        if (!stop_ok) fe_exp++;
`else
        stored = 1'b1;
`endif
        if (stored && exp_q.size() < DEPTH) exp_q.push_back(d);
    endtask

    task automatic pop_one();
        rd_uart = 1'b1;
        step(1);
        rd_uart = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) pop_one();
        step(2);
        check_fifo_state();
    endtask

    initial begin
        step(3);
        check_reset_outputs();
        reset = 1'b0;
        step(5);

        // Single frame, no reads.
        send_and_model(8'hA5, 1'b1);
        check_fifo_state();
        drain();

        // Pop while empty is ignored.
        pop_one();
        step(2);
        check_fifo_state();

        // Short low glitch on idle line.
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(60);
        check_fifo_state();

        // Overflow: fifth byte is lost.
        for (int i = 1; i <= 5; i++) send_and_model(8'(i), 1'b1);
        check_fifo_state();
        drain();

        // Bad stop bit.
        send_and_model(8'h3C, 1'b0);
        check_fifo_state();
        drain();

        // Full FIFO with a pop landing on the push cycle of 0x66.
        for (int i = 0; i < DEPTH; i++) send_and_model(8'($urandom_range(0, 255)), 1'b1);
        check_fifo_state();
        fork
            send_and_model(8'h66, 1'b1);
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 800 && !seen; i++) begin
                    if (dut.push_reg) seen = 1'b1;
                    else step(1);
                end
                chk("push_seen", 32'(seen), 32'd1);
                if (seen) pop_one();
            end
        join
        check_fifo_state();
        drain();

        // Reset during the data bits of 0xFF, then a clean 0x12.
        send_frame(8'hFF, 1'b1, 4 * BIT_CLK);
        check_fifo_state();
        send_and_model(8'h12, 1'b1);
        check_fifo_state();
        drain();

        // Randomized frames with random reads in between.
        for (int n = 0; n < 12; n++) begin
            int k;
            send_and_model(8'($urandom_range(0, 255)), ($urandom_range(0, 9) != 0));
            check_fifo_state();
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) pop_one();
            step(2);
            check_fifo_state();
        end
        drain();
        chk("frame_err_pulse_long", 32'(fe_long), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
